// File: rtl/risc_v_ex_wb.sv
// risc_v_ex_wb: execute and write-back back end for the two-stage RV32I front end.
// Holds the ID/EX and EX/WB registers, ALU, branch/jump resolution, operand forwarding and wrong-path flush.
module risc_v_ex_wb #(
  parameter logic FWD_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC_ID,
  input  logic [31:0] REG_DATA1_ID,
  input  logic [31:0] REG_DATA2_ID,
  input  logic [31:0] IMM_ID,
  input  logic [2:0]  FUNCT3_ID,
  input  logic [6:0]  FUNCT7_ID,
  input  logic [6:0]  OPCODE_ID,
  input  logic [4:0]  RD_ID,
  input  logic [4:0]  RS1_ID,
  input  logic [4:0]  RS2_ID,
  output logic        PCSrc,
  output logic [31:0] PC_Branch,
  output logic        PC_write,
  output logic        IF_ID_write,
  output logic        RegWrite_WB,
  output logic [31:0] ALU_DATA_WB,
  output logic [4:0]  RD_WB
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  function automatic logic is_supported(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH: is_supported = 1'b1;
      default:                                                 is_supported = 1'b0;
    endcase
  endfunction

  // ID/EX state
  logic        ex_valid_q, ex_valid_d;
  logic [31:0] ex_pc_q, ex_imm_q;
  logic [31:0] ex_op1_q, ex_op1_d, ex_op2_q, ex_op2_d;
  logic [2:0]  ex_funct3_q;
  logic        ex_f7b5_q;
  logic [6:0]  ex_opcode_q;
  logic [4:0]  ex_rd_q, ex_rs1_q, ex_rs2_q;
  logic        flush_cnt_q, flush_cnt_d;

  // EX/WB state
  logic        wb_we_q, wb_we_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [31:0] pc_branch_q, pc_branch_d;

  // EX combinational
  logic [31:0] op1_s, op2_s, alu_b_s, alu_s, result_s, target_s;
  logic [4:0]  shamt_s;
  logic        writes_s, redirect_s, taken_s;

  logic        unused_funct7_s;
  assign unused_funct7_s = ^{FUNCT7_ID[6], FUNCT7_ID[4:0]};

  // Capture-side decode, bubble insertion and register-file bypass from the WB port
  always_comb begin
    ex_valid_d  = 1'b0;
    ex_op1_d    = REG_DATA1_ID;
    ex_op2_d    = REG_DATA2_ID;
    flush_cnt_d = PCSrc;
    if (PCSrc || flush_cnt_q) begin
      ex_valid_d = 1'b0;
    end else begin
      ex_valid_d = is_supported(OPCODE_ID);
    end
    if (FWD_EN && wb_we_q && (wb_rd_q != 5'd0) && (wb_rd_q == RS1_ID)) begin
      ex_op1_d = wb_data_q;
    end else begin
      ex_op1_d = REG_DATA1_ID;
    end
    if (FWD_EN && wb_we_q && (wb_rd_q != 5'd0) && (wb_rd_q == RS2_ID)) begin
      ex_op2_d = wb_data_q;
    end else begin
      ex_op2_d = REG_DATA2_ID;
    end
  end

  // ID/EX pipeline register and flush counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid_q  <= 1'b0;
      ex_pc_q     <= 32'd0;
      ex_imm_q    <= 32'd0;
      ex_op1_q    <= 32'd0;
      ex_op2_q    <= 32'd0;
      ex_funct3_q <= 3'd0;
      ex_f7b5_q   <= 1'b0;
      ex_opcode_q <= 7'd0;
      ex_rd_q     <= 5'd0;
      ex_rs1_q    <= 5'd0;
      ex_rs2_q    <= 5'd0;
      flush_cnt_q <= 1'b0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_pc_q     <= PC_ID;
      ex_imm_q    <= IMM_ID;
      ex_op1_q    <= ex_op1_d;
      ex_op2_q    <= ex_op2_d;
      ex_funct3_q <= FUNCT3_ID;
      ex_f7b5_q   <= FUNCT7_ID[5];
      ex_opcode_q <= OPCODE_ID;
      ex_rd_q     <= RD_ID;
      ex_rs1_q    <= RS1_ID;
      ex_rs2_q    <= RS2_ID;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // EX operand forwarding (older result in EX/WB beats the captured value) and ALU
  always_comb begin
    op1_s   = ex_op1_q;
    op2_s   = ex_op2_q;
    alu_b_s = 32'd0;
    shamt_s = 5'd0;
    alu_s   = 32'd0;
    if (FWD_EN && wb_we_q && (wb_rd_q != 5'd0) && (wb_rd_q == ex_rs1_q)) begin
      op1_s = wb_data_q;
    end else begin
      op1_s = ex_op1_q;
    end
    if (FWD_EN && wb_we_q && (wb_rd_q != 5'd0) && (wb_rd_q == ex_rs2_q)) begin
      op2_s = wb_data_q;
    end else begin
      op2_s = ex_op2_q;
    end
    if (ex_opcode_q == OP_R) begin
      alu_b_s = op2_s;
    end else begin
      alu_b_s = ex_imm_q;
    end
    shamt_s = alu_b_s[4:0];
    case (ex_funct3_q)
      3'b000: begin
        if ((ex_opcode_q == OP_R) && ex_f7b5_q) begin
          alu_s = op1_s - alu_b_s;
        end else begin
          alu_s = op1_s + alu_b_s;
        end
      end
      3'b001: alu_s = op1_s << shamt_s;
      3'b010: alu_s = {31'd0, ($signed(op1_s) < $signed(alu_b_s))};
      3'b011: alu_s = {31'd0, (op1_s < alu_b_s)};
      3'b100: alu_s = op1_s ^ alu_b_s;
      3'b101: begin
        if (ex_f7b5_q) begin
          alu_s = $signed(op1_s) >>> shamt_s;
        end else begin
          alu_s = op1_s >> shamt_s;
        end
      end
      3'b110: alu_s = op1_s | alu_b_s;
      3'b111: alu_s = op1_s & alu_b_s;
      default: alu_s = 32'd0;
    endcase
  end

  // Branch condition; funct3 010/011 are not branch encodings and never take
  always_comb begin
    taken_s = 1'b0;
    case (ex_funct3_q)
      3'b000:  taken_s = (op1_s == op2_s);
      3'b001:  taken_s = (op1_s != op2_s);
      3'b100:  taken_s = ($signed(op1_s) < $signed(op2_s));
      3'b101:  taken_s = ($signed(op1_s) >= $signed(op2_s));
      3'b110:  taken_s = (op1_s < op2_s);
      3'b111:  taken_s = (op1_s >= op2_s);
      default: taken_s = 1'b0;
    endcase
  end

  // Per-opcode result selection, register-write intent and redirect target
  always_comb begin
    result_s   = 32'd0;
    writes_s   = 1'b0;
    redirect_s = 1'b0;
    target_s   = ex_pc_q + ex_imm_q;
    case (ex_opcode_q)
      OP_R, OP_I: begin
        result_s = alu_s;
        writes_s = 1'b1;
      end
      OP_LUI: begin
        result_s = ex_imm_q;
        writes_s = 1'b1;
      end
      OP_AUIPC: begin
        result_s = ex_pc_q + ex_imm_q;
        writes_s = 1'b1;
      end
      OP_JAL: begin
        result_s   = ex_pc_q + 32'd4;
        writes_s   = 1'b1;
        redirect_s = 1'b1;
      end
      OP_JALR: begin
        result_s   = ex_pc_q + 32'd4;
        writes_s   = 1'b1;
        redirect_s = 1'b1;
        target_s   = (op1_s + ex_imm_q) & 32'hFFFF_FFFE;
      end
      OP_BRANCH: begin
        redirect_s = taken_s;
      end
      default: begin
        result_s   = 32'd0;
        writes_s   = 1'b0;
        redirect_s = 1'b0;
      end
    endcase
  end

  assign PCSrc       = ex_valid_q & redirect_s;
  assign PC_Branch   = PCSrc ? target_s : pc_branch_q;
  assign PC_write    = 1'b1;
  assign IF_ID_write = 1'b1;

  // EX/WB next state: rd and data only move on a real write, otherwise hold
  always_comb begin
    wb_we_d     = ex_valid_q && writes_s && (ex_rd_q != 5'd0);
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    pc_branch_d = pc_branch_q;
    if (wb_we_d) begin
      wb_rd_d   = ex_rd_q;
      wb_data_d = result_s;
    end else begin
      wb_rd_d   = wb_rd_q;
      wb_data_d = wb_data_q;
    end
    if (PCSrc) begin
      pc_branch_d = target_s;
    end else begin
      pc_branch_d = pc_branch_q;
    end
  end

  // EX/WB pipeline register and last redirect target
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_we_q     <= 1'b0;
      wb_rd_q     <= 5'd0;
      wb_data_q   <= 32'd0;
      pc_branch_q <= 32'd0;
    end else begin
      wb_we_q     <= wb_we_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      pc_branch_q <= pc_branch_d;
    end
  end

  assign RegWrite_WB = wb_we_q;
  assign RD_WB       = wb_rd_q;
  assign ALU_DATA_WB = wb_data_q;

endmodule

// File: tb/tb_risc_v_ex_wb.sv
// tb_risc_v_ex_wb: directed-vector bench for risc_v_ex_wb.
// A second instance with forwarding disabled shares all inputs for the hazard-exposure cases.
module tb_risc_v_ex_wb;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_id, d1_id, d2_id, imm_id;
  logic [2:0]  f3_id;
  logic [6:0]  f7_id, op_id;
  logic [4:0]  rd_id, rs1_id, rs2_id;

  logic        pcsrc, pcw, ifidw, rw;
  logic [31:0] pcb, wdata;
  logic [4:0]  wrd;
  logic        nf_pcsrc, nf_pcw, nf_ifidw, nf_rw;
  logic [31:0] nf_pcb, nf_wdata;
  logic [4:0]  nf_wrd;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  risc_v_ex_wb #(.FWD_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .PC_ID(pc_id), .REG_DATA1_ID(d1_id), .REG_DATA2_ID(d2_id),
    .IMM_ID(imm_id), .FUNCT3_ID(f3_id), .FUNCT7_ID(f7_id), .OPCODE_ID(op_id),
    .RD_ID(rd_id), .RS1_ID(rs1_id), .RS2_ID(rs2_id),
    .PCSrc(pcsrc), .PC_Branch(pcb), .PC_write(pcw), .IF_ID_write(ifidw),
    .RegWrite_WB(rw), .ALU_DATA_WB(wdata), .RD_WB(wrd)
  );

  risc_v_ex_wb #(.FWD_EN(1'b0)) dut_nf (
    .clk(clk), .reset(reset), .PC_ID(pc_id), .REG_DATA1_ID(d1_id), .REG_DATA2_ID(d2_id),
    .IMM_ID(imm_id), .FUNCT3_ID(f3_id), .FUNCT7_ID(f7_id), .OPCODE_ID(op_id),
    .RD_ID(rd_id), .RS1_ID(rs1_id), .RS2_ID(rs2_id),
    .PCSrc(nf_pcsrc), .PC_Branch(nf_pcb), .PC_write(nf_pcw), .IF_ID_write(nf_ifidw),
    .RegWrite_WB(nf_rw), .ALU_DATA_WB(nf_wdata), .RD_WB(nf_wrd)
  );

  task automatic put(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                     input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [31:0] imm, input logic [31:0] pc,
                     input logic [31:0] d1, input logic [31:0] d2);
    op_id = op; f3_id = f3; f7_id = f7; rd_id = rd; rs1_id = rs1; rs2_id = rs2;
    imm_id = imm; pc_id = pc; d1_id = d1; d2_id = d2;
  endtask

  task automatic put_nop();
    put(7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    put(OP_I, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd9, 32'h10, 32'hDEAD, 32'hBEEF);
    #10;
    tests++; if (pcsrc !== 1'b0) begin $display("FAIL reset_pcsrc: got %b want 0", pcsrc); fails++; end
    tests++; if (pcb !== 32'd0) begin $display("FAIL reset_pcbranch: got %h want 0", pcb); fails++; end
    tests++; if (rw !== 1'b0) begin $display("FAIL reset_regwrite: got %b want 0", rw); fails++; end
    tests++; if (wdata !== 32'd0) begin $display("FAIL reset_data: got %h want 0", wdata); fails++; end
    tests++; if (wrd !== 5'd0) begin $display("FAIL reset_rd: got %0d want 0", wrd); fails++; end
    tests++; if ({pcw, ifidw} !== 2'b11) begin $display("FAIL reset_pcwrite: got %b want 11", {pcw, ifidw}); fails++; end
    reset = 1'b0;
    put(OP_I, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 32'd0, 32'd0, 32'd0);
    tick();
    tests++; if (rw !== 1'b0) begin $display("FAIL first_wb_early: got %b want 0", rw); fails++; end
    put_nop();
    tick();
    tests++; if ({rw, wrd, wdata} !== {1'b1, 5'd1, 32'd5}) begin
      $display("FAIL first_wb: got we=%b rd=%0d data=%h want 1/1/5", rw, wrd, wdata); fails++; end
  endtask

  typedef struct packed {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] exp;
  } vec_t;

  task automatic test_alu();
    vec_t v [13];
    put(OP_I, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 32'd0, 32'd0, 32'd0);
    tick();
    put(OP_I, 3'b000, 7'd0, 5'd2, 5'd0, 5'd0, 32'hFFFF_FFFD, 32'd0, 32'd0, 32'd0);
    tick();
    tests++; if ({rw, wrd, wdata} !== {1'b1, 5'd1, 32'd5}) begin
      $display("FAIL addi_x1: got we=%b rd=%0d data=%h want 1/1/5", rw, wrd, wdata); fails++; end
    put(OP_R, 3'b000, 7'b0100000, 5'd3, 5'd1, 5'd2, 32'd0, 32'd0, 32'd5, 32'hFFFF_FFFD);
    tick();
    tests++; if ({rw, wrd, wdata} !== {1'b1, 5'd2, 32'hFFFF_FFFD}) begin
      $display("FAIL addi_x2: got we=%b rd=%0d data=%h want 1/2/fffffffd", rw, wrd, wdata); fails++; end
    put_nop();
    tick();
    tests++; if ({rw, wrd, wdata} !== {1'b1, 5'd3, 32'd8}) begin
      $display("FAIL sub_x3: got we=%b rd=%0d data=%h want 1/3/8", rw, wrd, wdata); fails++; end

    v = '{
      '{OP_R,     3'b101, 7'b0100000, 32'd0,       32'd0,     32'h8000_0000, 32'd4,         32'hF800_0000},
      '{OP_R,     3'b101, 7'b0000000, 32'd0,       32'd0,     32'h8000_0000, 32'd4,         32'h0800_0000},
      '{OP_R,     3'b010, 7'b0000000, 32'd0,       32'd0,     32'hFFFF_FFFF, 32'd1,         32'd1},
      '{OP_R,     3'b011, 7'b0000000, 32'd0,       32'd0,     32'hFFFF_FFFF, 32'd1,         32'd0},
      '{OP_R,     3'b100, 7'b0000000, 32'd0,       32'd0,     32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00},
      '{OP_R,     3'b110, 7'b0000000, 32'd0,       32'd0,     32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0},
      '{OP_R,     3'b111, 7'b0000000, 32'd0,       32'd0,     32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0},
      '{OP_R,     3'b001, 7'b0000000, 32'd0,       32'd0,     32'd1,         32'h24,        32'h10},
      '{OP_R,     3'b000, 7'b0000000, 32'd0,       32'd0,     32'hFFFF_FFFF, 32'd1,         32'd0},
      '{OP_I,     3'b101, 7'b0100000, 32'd4,       32'd0,     32'h8000_0000, 32'd99,        32'hF800_0000},
      '{OP_I,     3'b000, 7'b0100000, 32'd5,       32'd0,     32'd10,        32'd99,        32'd15},
      '{OP_LUI,   3'b000, 7'b0000000, 32'h1234_5000, 32'd0,   32'd7,         32'd7,         32'h1234_5000},
      '{OP_AUIPC, 3'b000, 7'b0000000, 32'h1000,    32'h100,   32'd7,         32'd7,         32'h1100}
    };
    for (int i = 0; i < 13; i++) begin
      put(v[i].op, v[i].f3, v[i].f7, 5'd12, 5'd10, 5'd11, v[i].imm, v[i].pc, v[i].d1, v[i].d2);
      tick();
      put_nop();
      tick();
      tests++; if ({rw, wrd, wdata} !== {1'b1, 5'd12, v[i].exp}) begin
        $display("FAIL alu_vec%0d: got we=%b rd=%0d data=%h want 1/12/%h", i, rw, wrd, wdata, v[i].exp); fails++; end
    end
  endtask

  task automatic test_forward();
    // back-to-back dependency: EX forward
    put(OP_I, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd7, 32'd0, 32'd0, 32'd0);
    tick();
    put(OP_R, 3'b000, 7'd0, 5'd2, 5'd1, 5'd1, 32'd0, 32'd0, 32'd0, 32'd0);
    tick();
    put_nop();
    tick();
    tests++; if ({rw, wrd, wdata} !== {1'b1, 5'd2, 32'd14}) begin
      $display("FAIL fwd_ex: got we=%b rd=%0d data=%h want 1/2/e", rw, wrd, wdata); fails++; end
    tests++; if (nf_wdata !== 32'd0) begin $display("FAIL nofwd_ex: got %h want 0", nf_wdata); fails++; end
    // one independent instruction between: capture bypass
    put(OP_I, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd7, 32'd0, 32'd0, 32'd0);
    tick();
    put(OP_I, 3'b000, 7'd0, 5'd9, 5'd0, 5'd0, 32'd1, 32'd0, 32'd0, 32'd0);
    tick();
    put(OP_R, 3'b000, 7'd0, 5'd2, 5'd1, 5'd1, 32'd0, 32'd0, 32'd0, 32'd0);
    tick();
    put_nop();
    tick();
    tests++; if ({rw, wrd, wdata} !== {1'b1, 5'd2, 32'd14}) begin
      $display("FAIL fwd_capture: got we=%b rd=%0d data=%h want 1/2/e", rw, wrd, wdata); fails++; end
    tests++; if (nf_wdata !== 32'd0) begin $display("FAIL nofwd_capture: got %h want 0", nf_wdata); fails++; end
    // both paths hit x1: the younger (EX forward) value of 9 must win over captured 7
    put(OP_I, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd7, 32'd0, 32'd0, 32'd0);
    tick();
    put(OP_I, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd9, 32'd0, 32'd0, 32'd0);
    tick();
    put(OP_R, 3'b000, 7'd0, 5'd2, 5'd1, 5'd1, 32'd0, 32'd0, 32'd0, 32'd0);
    tick();
    put_nop();
    tick();
    tests++; if ({rw, wrd, wdata} !== {1'b1, 5'd2, 32'd18}) begin
      $display("FAIL fwd_priority: got we=%b rd=%0d data=%h want 1/2/12", rw, wrd, wdata); fails++; end
  endtask

  task automatic test_branch();
    put(OP_BRANCH, 3'b000, 7'd0, 5'd0, 5'd10, 5'd11, 32'h20, 32'h40, 32'h55, 32'h55);
    tick();
    tests++; if ({pcsrc, pcb} !== {1'b1, 32'h60}) begin
      $display("FAIL beq_redirect: got pcsrc=%b target=%h want 1/60", pcsrc, pcb); fails++; end
    put(OP_I, 3'b000, 7'd0, 5'd5, 5'd0, 5'd0, 32'd1, 32'h44, 32'd0, 32'd0);
    tick();
    tests++; if ({pcsrc, pcb, rw} !== {1'b0, 32'h60, 1'b0}) begin
      $display("FAIL beq_one_cycle: got pcsrc=%b target=%h we=%b want 0/60/0", pcsrc, pcb, rw); fails++; end
    put(OP_I, 3'b000, 7'd0, 5'd6, 5'd0, 5'd0, 32'd1, 32'h60, 32'd0, 32'd0);
    tick();
    tests++; if (rw !== 1'b0) begin $display("FAIL flush_x5: got we=%b want 0", rw); fails++; end
    put(OP_I, 3'b000, 7'd0, 5'd7, 5'd0, 5'd0, 32'd1, 32'h64, 32'd0, 32'd0);
    tick();
    tests++; if (rw !== 1'b0) begin $display("FAIL flush_x6: got we=%b want 0", rw); fails++; end
    put_nop();
    tick();
    tests++; if ({rw, wrd, wdata} !== {1'b1, 5'd7, 32'd1}) begin
      $display("FAIL after_flush: got we=%b rd=%0d data=%h want 1/7/1", rw, wrd, wdata); fails++; end
  endtask

  task automatic test_unsigned();
    put(OP_BRANCH, 3'b110, 7'd0, 5'd0, 5'd10, 5'd11, 32'h10, 32'h200, 32'hFFFF_FFFF, 32'd1);
    tick();
    tests++; if (pcsrc !== 1'b0) begin $display("FAIL bltu_not_taken: got %b want 0", pcsrc); fails++; end
    put(OP_BRANCH, 3'b010, 7'd0, 5'd0, 5'd10, 5'd11, 32'h10, 32'h204, 32'd3, 32'd3);
    tick();
    tests++; if (pcsrc !== 1'b0) begin $display("FAIL f3_010_never: got %b want 0", pcsrc); fails++; end
    put(OP_BRANCH, 3'b100, 7'd0, 5'd0, 5'd10, 5'd11, 32'h10, 32'h200, 32'hFFFF_FFFF, 32'd1);
    tick();
    tests++; if ({pcsrc, pcb} !== {1'b1, 32'h210}) begin
      $display("FAIL blt_taken: got pcsrc=%b target=%h want 1/210", pcsrc, pcb); fails++; end
    put_nop();
    tick();
    tick();
  endtask

  task automatic test_jump();
    put(OP_JALR, 3'b000, 7'd0, 5'd1, 5'd10, 5'd0, 32'd4, 32'h80, 32'h101, 32'd0);
    tick();
    tests++; if ({pcsrc, pcb} !== {1'b1, 32'h104}) begin
      $display("FAIL jalr_target: got pcsrc=%b target=%h want 1/104", pcsrc, pcb); fails++; end
    put_nop();
    tick();
    tests++; if ({rw, wrd, wdata} !== {1'b1, 5'd1, 32'h84}) begin
      $display("FAIL jalr_link: got we=%b rd=%0d data=%h want 1/1/84", rw, wrd, wdata); fails++; end
    tick();
    put(OP_JAL, 3'b000, 7'd0, 5'd2, 5'd0, 5'd0, 32'h100, 32'h300, 32'd0, 32'd0);
    tick();
    tests++; if ({pcsrc, pcb} !== {1'b1, 32'h400}) begin
      $display("FAIL jal_target: got pcsrc=%b target=%h want 1/400", pcsrc, pcb); fails++; end
    put_nop();
    tick();
    tests++; if ({rw, wrd, wdata} !== {1'b1, 5'd2, 32'h304}) begin
      $display("FAIL jal_link: got we=%b rd=%0d data=%h want 1/2/304", rw, wrd, wdata); fails++; end
    tick();
    // reset in the cycle after the redirect
    put(OP_JALR, 3'b000, 7'd0, 5'd1, 5'd10, 5'd0, 32'd4, 32'h80, 32'h101, 32'd0);
    tick();
    tests++; if (pcsrc !== 1'b1) begin $display("FAIL jalr2_redirect: got %b want 1", pcsrc); fails++; end
    reset = 1'b1;
    put(OP_I, 3'b000, 7'd0, 5'd5, 5'd0, 5'd0, 32'd1, 32'h84, 32'd0, 32'd0);
    #1;
    tests++; if ({pcsrc, pcb} !== {1'b0, 32'd0}) begin
      $display("FAIL reset_drop_pcsrc: got pcsrc=%b target=%h want 0/0", pcsrc, pcb); fails++; end
    tick();
    tests++; if (rw !== 1'b0) begin $display("FAIL reset_discard: got we=%b want 0", rw); fails++; end
    reset = 1'b0;
    put(OP_I, 3'b000, 7'd0, 5'd8, 5'd0, 5'd0, 32'd3, 32'h0, 32'd0, 32'd0);
    tick();
    tests++; if (rw !== 1'b0) begin $display("FAIL reset_stays0: got we=%b want 0", rw); fails++; end
    put_nop();
    tick();
    tests++; if ({rw, wrd, wdata} !== {1'b1, 5'd8, 32'd3}) begin
      $display("FAIL reset_flush_clear: got we=%b rd=%0d data=%h want 1/8/3", rw, wrd, wdata); fails++; end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_forward();
    test_branch();
    test_unsigned();
    test_jump();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
